// File: rtl/blake2s_msg_feeder.sv
// blake2s_msg_feeder: buffers a byte-serial message into 64-byte blocks and
// streams each block to a BLAKE2s core, zero padding the final partial block.
// It tracks the running byte count and first/last flags, then counts digest
// bytes coming back and pulses done_o once nn bytes have been returned.
// Optional build macro: BLAKE2S_FEEDER_HASH_COLLECT_EN gathers the digest into
// hash_o and qualifies it with hash_v_o.
module blake2s_msg_feeder (
    input  logic         clk,
    input  logic         nreset,
    input  logic         start_i,
    input  logic [5:0]   nn_i,
    input  logic         empty_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [7:0]   s_data_i,
    input  logic         s_last_i,
    input  logic         core_ready_v_i,
    output logic [5:0]   core_kk_o,
    output logic [5:0]   core_nn_o,
    output logic [63:0]  core_ll_o,
    output logic         core_block_first_o,
    output logic         core_block_last_o,
    output logic         core_data_v_o,
    output logic [5:0]   core_data_idx_o,
    output logic [7:0]   core_data_o,
    input  logic         core_h_v_i,
    input  logic [7:0]   core_h_i,
`ifdef BLAKE2S_FEEDER_HASH_COLLECT_EN
    output logic [255:0] hash_o,
    output logic         hash_v_o,
`endif
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        WAIT_RDY  = 3'd2,
        SEND      = 3'd3,
        WAIT_HASH = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  fill_q, fill_d;     // bytes held in the block buffer, 0..64
    logic [63:0] cnt_q, cnt_d;       // total message bytes accepted
    logic [5:0]  nn_q, nn_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic [5:0]  idx_q, idx_d;       // byte index while streaming a block
    logic [5:0]  hcnt_q, hcnt_d;     // digest bytes received
    logic [5:0]  hcnt_inc;
    logic        done_q, done_d;
    logic        wr_en;
    logic [7:0]  mem_q [64];

`ifdef BLAKE2S_FEEDER_HASH_COLLECT_EN
    logic [255:0] hash_q, hash_d;
`else
    // Digest bytes are only counted in this build, their values are not used.
    logic unused_h;
    assign unused_h = ^core_h_i;
`endif

    assign hcnt_inc = hcnt_q + 6'd1;

    // Next-state and datapath updates for the block sequencing FSM.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        nn_d    = nn_q;
        first_d = first_q;
        last_d  = last_q;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
`ifdef BLAKE2S_FEEDER_HASH_COLLECT_EN
        hash_d  = hash_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    nn_d    = nn_i;
                    cnt_d   = '0;
                    fill_d  = '0;
                    idx_d   = '0;
                    hcnt_d  = '0;
                    first_d = 1'b1;
                    // An empty message still needs one all-zero final block.
                    last_d  = empty_i;
                    state_d = empty_i ? WAIT_RDY : FILL;
`ifdef BLAKE2S_FEEDER_HASH_COLLECT_EN
                    hash_d  = '0;
`endif
                end
            end
            FILL: begin
                // s_ready_o is high throughout FILL, so valid alone is a handshake.
                if (s_valid_i) begin
                    wr_en  = 1'b1;
                    fill_d = fill_q + 7'd1;
                    cnt_d  = cnt_q + 64'd1;
                    if (s_last_i) begin
                        last_d = 1'b1;
                    end
                    // A full block that is not the last byte holds last low, so a
                    // 64*k byte message never produces a trailing pad block.
                    if (s_last_i || fill_q == 7'd63) begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (core_ready_v_i) begin
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    if (last_q) begin
                        state_d = WAIT_HASH;
                    end else begin
                        fill_d  = '0;
                        first_d = 1'b0;
                        state_d = FILL;
                    end
                end
            end
            WAIT_HASH: begin
                if (core_h_v_i) begin
                    hcnt_d = hcnt_inc;
`ifdef BLAKE2S_FEEDER_HASH_COLLECT_EN
                    if (hcnt_q < 6'd32) begin
                        hash_d[{hcnt_q[4:0], 3'b000} +: 8] = core_h_i;
                    end
`endif
                    if (hcnt_inc == nn_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            fill_q  <= '0;
            cnt_q   <= '0;
            nn_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            hcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            nn_q    <= nn_d;
            first_q <= first_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            done_q  <= done_d;
        end
    end

    // Block buffer; contents are only read below the fill level, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[fill_q[5:0]] <= s_data_i;
        end
    end

`ifdef BLAKE2S_FEEDER_HASH_COLLECT_EN
    // Digest collection register, held until the next message starts.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            hash_q <= '0;
        end else begin
            hash_q <= hash_d;
        end
    end

    assign hash_o   = hash_q;
    assign hash_v_o = done_q;
`endif

    assign s_ready_o          = (state_q == FILL);
    assign busy_o             = (state_q != IDLE);
    assign done_o             = done_q;
    assign core_kk_o          = 6'd0;
    assign core_nn_o          = nn_q;
    assign core_ll_o          = cnt_q;
    assign core_block_first_o = first_q;
    assign core_block_last_o  = last_q;
    assign core_data_v_o      = (state_q == SEND);
    assign core_data_idx_o    = idx_q;
    // Bytes past the fill level of the final block are zero padding.
    assign core_data_o        = ((state_q == SEND) && ({1'b0, idx_q} < fill_q))
                                ? mem_q[idx_q] : 8'h00;

endmodule

// File: tb/tb_blake2s_msg_feeder.sv
// Directed bench for blake2s_msg_feeder: a table of messages is pushed through
// the feeder, each streamed block is compared against a byte-level model, and
// a reset-during-SEND sequence is exercised by hand.
module tb_blake2s_msg_feeder;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  nn_i = '0;
    logic        empty_i = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  s_data_i = '0;
    logic        s_last_i = 1'b0;
    logic        core_ready_v_i = 1'b1;
    logic [5:0]  core_kk_o;
    logic [5:0]  core_nn_o;
    logic [63:0] core_ll_o;
    logic        core_block_first_o;
    logic        core_block_last_o;
    logic        core_data_v_o;
    logic [5:0]  core_data_idx_o;
    logic [7:0]  core_data_o;
    logic        core_h_v_i = 1'b0;
    logic [7:0]  core_h_i = '0;
    logic        busy_o;
    logic        done_o;

    blake2s_msg_feeder dut (
        .clk(clk), .nreset(nreset), .start_i(start_i), .nn_i(nn_i),
        .empty_i(empty_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_data_i(s_data_i), .s_last_i(s_last_i), .core_ready_v_i(core_ready_v_i),
        .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
        .core_block_first_o(core_block_first_o), .core_block_last_o(core_block_last_o),
        .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o),
        .core_data_o(core_data_o), .core_h_v_i(core_h_v_i), .core_h_i(core_h_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          len;
        bit          abc;
        bit          empty;
        logic [5:0]  nn;
        int          stall;
        int          exp_blocks;
        logic [63:0] exp_ll;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input bit abc, input int k);
        int v;
        v = abc ? (97 + k) : ((k * 37 + 5) & 255);
        return 8'(v);
    endfunction

    // Drive one message through start, byte stream, core handshake and digest.
    task automatic run_msg(input vec_t v, input string tag);
        int sent, blk, hsent, stall_left, waited, exp_idx, rose_cyc, cyc;
        int bad_data, bad_meta, bad_idx, first_bad, base;
        bit hon, arm, got_done, done_due, done_err, prev_dv, seen_send, waitrdy;
        logic [7:0]  eb;
        logic [63:0] ell;
        sent = 0; blk = 0; hsent = 0; stall_left = v.stall; waited = 0;
        exp_idx = 0; rose_cyc = -10; bad_data = 0; bad_meta = 0; bad_idx = 0;
        first_bad = -1; hon = 0; got_done = 0; done_due = 0; done_err = 0;
        prev_dv = 0; seen_send = 0;
        @(negedge clk);
        start_i = 1'b1; nn_i = v.nn; empty_i = v.empty;
        for (cyc = 0; cyc < 2000 && !got_done; cyc++) begin
            @(negedge clk);
            start_i = 1'b0; empty_i = 1'b0; arm = 0;
            if (done_o !== done_due) done_err = 1;
            if (done_o === 1'b1) got_done = 1;
            done_due = 0;
            if (core_data_v_o === 1'b1) begin
                if (!seen_send) begin
                    seen_send = 1;
                    if (v.stall > 0) chk({tag, "_send_after_ready"}, 64'(cyc), 64'(rose_cyc + 1));
                end
                if (!prev_dv) begin
                    exp_idx = 0; bad_data = 0; bad_meta = 0; bad_idx = 0; first_bad = -1;
                end
                base = blk * 64;
                eb = (base + exp_idx < v.len) ? msg_byte(v.abc, base + exp_idx) : 8'h00;
                ell = (base + 64 < v.len) ? 64'(base + 64) : 64'(v.len);
                if (core_data_idx_o !== 6'(exp_idx)) bad_idx++;
                if (core_data_o !== eb) begin
                    bad_data++;
                    if (first_bad < 0) first_bad = exp_idx;
                end
                if (core_block_first_o !== (blk == 0) ||
                    core_block_last_o !== (blk == v.exp_blocks - 1) ||
                    core_ll_o !== ell) bad_meta++;
                if (exp_idx == 63) begin
                    chk($sformatf("%s_blk%0d_data_bad(first@%0d)", tag, blk, first_bad), 64'(bad_data), 64'd0);
                    chk($sformatf("%s_blk%0d_meta_bad", tag, blk), 64'(bad_meta), 64'd0);
                    chk($sformatf("%s_blk%0d_idx_bad", tag, blk), 64'(bad_idx), 64'd0);
                    if (blk == v.exp_blocks - 1) chk({tag, "_final_ll"}, core_ll_o, v.exp_ll);
                    if (core_block_last_o === 1'b1) arm = 1;
                    blk++;
                end
                exp_idx++;
            end
            prev_dv = (core_data_v_o === 1'b1);
            // Source side: offer the next byte; accepted only while ready.
            s_valid_i = !v.empty && (sent < v.len);
            s_data_i  = msg_byte(v.abc, sent);
            s_last_i  = (sent == v.len - 1);
            if (s_valid_i && s_ready_o === 1'b1) sent++;
            // Core side: stall the ready handshake while the feeder waits.
            waitrdy = (busy_o === 1'b1) && (s_ready_o === 1'b0) && (core_data_v_o === 1'b0) && !hon;
            if (waitrdy) begin
                if (stall_left > 0) begin
                    core_ready_v_i = 1'b0; stall_left--; waited++;
                end else begin
                    if (core_ready_v_i == 1'b0) rose_cyc = cyc;
                    core_ready_v_i = 1'b1;
                end
            end
            if (hon && hsent < int'(v.nn)) begin
                core_h_v_i = 1'b1; core_h_i = 8'(hsent); hsent++;
                if (hsent == int'(v.nn)) done_due = 1;
            end else begin
                core_h_v_i = 1'b0;
            end
            if (arm) hon = 1;
        end
        s_valid_i = 1'b0; s_last_i = 1'b0; core_h_v_i = 1'b0; core_ready_v_i = 1'b1;
        chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
        chk({tag, "_done_timing_err"}, 64'(done_err), 64'd0);
        chk({tag, "_blocks"}, 64'(blk), 64'(v.exp_blocks));
        chk({tag, "_bytes_taken"}, 64'(sent), 64'(v.len));
        chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
        chk({tag, "_nn_latched"}, 64'(core_nn_o), 64'(v.nn));
        chk({tag, "_kk"}, 64'(core_kk_o), 64'd0);
        if (v.stall > 0) chk({tag, "_stall_cycles"}, 64'(waited), 64'(v.stall));
    endtask

    initial begin
        int  sent;
        bit  found;
        tbl[0] = '{0,   1'b0, 1'b1, 6'd32, 0,  1, 64'd0};
        tbl[1] = '{3,   1'b1, 1'b0, 6'd32, 0,  1, 64'd3};
        tbl[2] = '{64,  1'b0, 1'b0, 6'd16, 0,  1, 64'd64};
        tbl[3] = '{65,  1'b0, 1'b0, 6'd32, 0,  2, 64'd65};
        tbl[4] = '{10,  1'b0, 1'b0, 6'd8,  10, 1, 64'd10};
        tbl[5] = '{128, 1'b0, 1'b0, 6'd1,  0,  2, 64'd128};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ll", core_ll_o, 64'd0);
        chk("rst_outs", 64'({s_ready_o, core_kk_o, core_nn_o, core_block_first_o,
                            core_block_last_o, core_data_v_o, core_data_idx_o,
                            core_data_o, busy_o, done_o}), 64'd0);
        nreset = 1'b1;

        for (int i = 0; i < 6; i++) run_msg(tbl[i], $sformatf("vec%0d", i));

        // Reset while streaming byte 20 of an "abc" block.
        @(negedge clk);
        start_i = 1'b1; nn_i = 6'd32; empty_i = 1'b0;
        sent = 0; found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (core_data_v_o === 1'b1 && core_data_idx_o === 6'd20) begin
                found = 1;
            end else begin
                s_valid_i = (sent < 3);
                s_data_i  = msg_byte(1'b1, sent);
                s_last_i  = (sent == 2);
                if (s_valid_i && s_ready_o === 1'b1) sent++;
            end
        end
        chk("rst_mid_reached_idx20", 64'(found), 64'd1);
        s_valid_i = 1'b0; s_last_i = 1'b0;
        nreset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ll", core_ll_o, 64'd0);
        chk("rst_mid_outs", 64'({s_ready_o, core_kk_o, core_nn_o, core_block_first_o,
                                core_block_last_o, core_data_v_o, core_data_idx_o,
                                core_data_o, busy_o, done_o}), 64'd0);
        nreset = 1'b1;
        run_msg(tbl[1], "abc_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
